// File: rtl/softmax_tile_dispatch_ctrl.sv
// softmax_tile_dispatch_ctrl
//   Steers the B2R tile stream onto the bank of row-wise softmax units.
//   Tiles arrive tile-major: (t0,r0)..(t0,rN-1),(t1,r0)... They pass through a
//   single output register. Each registered tile is offered to its row with a
//   one-hot valid. After the last tile drains, the block waits for every row's
//   done pulse. It then pulses b2r_rst_n low and raises slice_done.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               begin one slice (ignored unless idle)
//   in_valid/in_ready   B2R tile handshake, in_data tile payload
//   softmax_en          softmax bank enable
//   sm_valid/sm_ready   per-row one-hot valid / per-row ready
//   sm_data             registered tile shared by all rows
//   sm_tile_idx/sm_last column index of the tile, last-tile-of-row flag
//   sm_done             per-row completion pulse
//   b2r_rst_n           active-low reset to the B2R converter
//   slice_done          single-cycle slice completion pulse
//   busy                controller not idle
//   stall_cnt           (only with STALL_CNT_EN) saturating output-stall counter
//
// Optional feature macro: STALL_CNT_EN
module softmax_tile_dispatch_ctrl #(
    parameter int WIDTH          = 16,
    parameter int COL            = 64,
    parameter int TILE_SIZE      = 8,
    parameter int NUM_CORES      = 2,
    parameter int BLOCK_SIZE     = 2,
    parameter int B2R_RST_CYCLES = 2,
    localparam int NUM_ROWS  = NUM_CORES * BLOCK_SIZE,
    localparam int NUM_TILES = COL / TILE_SIZE,
    localparam int TILE_W    = WIDTH * TILE_SIZE,
    localparam int TI_W      = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [TILE_W-1:0]   in_data,
    output logic                softmax_en,
    output logic [NUM_ROWS-1:0] sm_valid,
    input  logic [NUM_ROWS-1:0] sm_ready,
    output logic [TILE_W-1:0]   sm_data,
    output logic [TI_W-1:0]     sm_tile_idx,
    output logic                sm_last,
    input  logic [NUM_ROWS-1:0] sm_done,
    output logic                b2r_rst_n,
    output logic                slice_done,
    output logic                busy
`ifdef STALL_CNT_EN
    ,
    output logic [31:0]         stall_cnt
`endif
);

    localparam int RI_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int FC_W = (B2R_RST_CYCLES > 1) ? $clog2(B2R_RST_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FLUSH} state_t;

    state_t              state, state_next;
    logic [RI_W-1:0]     row_idx;
    logic [RI_W-1:0]     cur_row;
    logic [TI_W-1:0]     tile_idx;
    logic                all_accepted;
    logic [NUM_ROWS-1:0] done_flags;
    logic [FC_W-1:0]     flush_cnt;

    logic out_full, out_drain, accept, start_ok, last_in, row_wrap, tile_wrap;

    always_comb begin
        out_full   = |sm_valid;
        out_drain  = out_full && sm_ready[cur_row];
        // Depends only on registered state and sm_ready, never on in_valid.
        in_ready   = (state == STREAM) && (!out_full || sm_ready[cur_row]) && !all_accepted;
        accept     = in_valid && in_ready;
        start_ok   = (state == IDLE) && start;
        row_wrap   = (row_idx == RI_W'(NUM_ROWS - 1));
        tile_wrap  = (tile_idx == TI_W'(NUM_TILES - 1));
        last_in    = row_wrap && tile_wrap;
        busy       = (state != IDLE);
        slice_done = (state == FLUSH) && (flush_cnt == '0);
        b2r_rst_n  = rst_n && (state != FLUSH);

        state_next = state;
        case (state)
            IDLE:    if (start) state_next = STREAM;
            STREAM:  if (all_accepted && (!out_full || out_drain)) state_next = DRAIN;
            DRAIN:   if (&done_flags) state_next = FLUSH;
            FLUSH:   if (flush_cnt == FC_W'(B2R_RST_CYCLES - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_idx      <= '0;
            tile_idx     <= '0;
            cur_row      <= '0;
            all_accepted <= 1'b0;
            done_flags   <= '0;
            flush_cnt    <= '0;
            softmax_en   <= 1'b0;
            sm_valid     <= '0;
            sm_data      <= '0;
            sm_tile_idx  <= '0;
            sm_last      <= 1'b0;
        end else begin
            if (start_ok) begin
                row_idx      <= '0;
                tile_idx     <= '0;
                all_accepted <= 1'b0;
                done_flags   <= '0;
                softmax_en   <= 1'b1;
            end

            // Load wins over drain: a same-cycle drain+accept replaces the tile.
            if (accept) begin
                sm_valid    <= NUM_ROWS'(1) << row_idx;
                sm_data     <= in_data;
                sm_tile_idx <= tile_idx;
                sm_last     <= tile_wrap;
                cur_row     <= row_idx;
                if (last_in) all_accepted <= 1'b1;
                if (row_wrap) begin
                    row_idx  <= '0;
                    tile_idx <= tile_wrap ? '0 : tile_idx + TI_W'(1);
                end else begin
                    row_idx  <= row_idx + RI_W'(1);
                end
            end else if (out_drain) begin
                sm_valid <= '0;
            end

            if (state == STREAM || state == DRAIN)
                done_flags <= done_flags | sm_done;

            if (state == FLUSH) begin
                done_flags <= '0;
                if (state_next == IDLE) begin
                    flush_cnt  <= '0;
                    softmax_en <= 1'b0;
                end else begin
                    flush_cnt <= flush_cnt + FC_W'(1);
                end
            end
        end
    end

`ifdef STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (start_ok)
            stall_cnt <= '0;
        else if (out_full && !sm_ready[cur_row] && stall_cnt != '1)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_softmax_tile_dispatch_ctrl.sv
// Self-checking bench for softmax_tile_dispatch_ctrl (default parameters).
// A scoreboard queue gets one entry per accepted tile. Entries are popped
// and compared when the selected row completes its output handshake.
module tb_softmax_tile_dispatch_ctrl;

    localparam int NR = 4;
    localparam int NT = 8;
    localparam int TW = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] in_data;
    logic          softmax_en;
    logic [NR-1:0] sm_valid;
    logic [NR-1:0] sm_ready;
    logic [TW-1:0] sm_data;
    logic [2:0]    sm_tile_idx;
    logic          sm_last;
    logic [NR-1:0] sm_done;
    logic          b2r_rst_n;
    logic          slice_done;
    logic          busy;
`ifdef STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    softmax_tile_dispatch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .softmax_en(softmax_en), .sm_valid(sm_valid), .sm_ready(sm_ready),
        .sm_data(sm_data), .sm_tile_idx(sm_tile_idx), .sm_last(sm_last),
        .sm_done(sm_done), .b2r_rst_n(b2r_rst_n), .slice_done(slice_done),
        .busy(busy)
`ifdef STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    row;
        logic [2:0]    tile;
        logic [TW-1:0] data;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   n_push = 0;
    int   n_pop = 0;
    int   stall_seen = 0;
    logic [1:0] exp_row = '0;
    logic [2:0] exp_tile = '0;

    // Fresh payload every cycle; only the accepted value enters the scoreboard.
    always @(posedge clk) begin
        #1 in_data = {$urandom, $urandom, $urandom, $urandom};
    end

    // Scoreboard monitor, sampling at the falling edge.
    always @(negedge clk) begin
        if (in_valid && in_ready) begin
            q.push_back('{row: exp_row, tile: exp_tile, data: in_data});
            n_push++;
            if (exp_row == 2'd3) exp_tile = exp_tile + 3'd1;
            exp_row = exp_row + 2'd1;
        end
        if (|sm_valid) begin
            if ((sm_valid & sm_ready) != '0) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_empty: got sm_valid=%b with no tile expected", sm_valid);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    n_pop++;
                    if (sm_valid !== (4'b0001 << e.row) || sm_tile_idx !== e.tile ||
                        sm_data !== e.data || sm_last !== (e.tile == 3'd7)) begin
                        bad++;
                        $display("FAIL sb_tile: got valid=%b idx=%0d last=%b data=%h, want valid=%b idx=%0d last=%b data=%h",
                                 sm_valid, sm_tile_idx, sm_last, sm_data,
                                 4'b0001 << e.row, e.tile, e.tile == 3'd7, e.data);
                    end
                end
            end else begin
                stall_seen++;
            end
        end
    end

    task automatic sb_reset();
        q.delete();
        n_push = 0;
        n_pop = 0;
        stall_seen = 0;
        exp_row = '0;
        exp_tile = '0;
    endtask

    task automatic start_slice();
        sb_reset();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic pulse_done(input logic [NR-1:0] rows);
        @(posedge clk); #1 sm_done = rows;
        @(posedge clk); #1 sm_done = '0;
    endtask

    // Walks FLUSH, counting slice_done and b2r_rst_n-low cycles until idle.
    task automatic check_flush(input string name);
        int sd = 0;
        int bl = 0;
        bit seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (slice_done) sd++;
            if (!b2r_rst_n) begin bl++; seen = 1; end
            if (seen && !busy) break;
        end
        total++;
        if (sd !== 1 || bl !== 2 || busy !== 1'b0 || softmax_en !== 1'b0) begin
            bad++;
            $display("FAIL %s: slice_done cycles=%0d b2r low=%0d busy=%b en=%b, want 1 2 0 0",
                     name, sd, bl, busy, softmax_en);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; sm_ready = '1; sm_done = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({in_ready, sm_valid, sm_tile_idx, sm_last, softmax_en, b2r_rst_n, slice_done, busy} !== '0 ||
            sm_data !== '0) begin
            bad++;
            $display("FAIL reset_vals: rdy=%b v=%b idx=%0d last=%b en=%b b2r=%b sd=%b busy=%b data=%h, want all 0",
                     in_ready, sm_valid, sm_tile_idx, sm_last, softmax_en, b2r_rst_n, slice_done, busy, sm_data);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (b2r_rst_n !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2r_after_reset: b2r_rst_n=%b busy=%b, want 1 0", b2r_rst_n, busy);
        end
    endtask

    task automatic test_stream();
        int acc = 0;
        int first = -1;
        int last = -1;
        bit first_chk = 0;
        start_slice();
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 200 && acc < 32; cyc++) begin
            @(negedge clk);
            if (acc == 1 && !first_chk) begin
                first_chk = 1;
                total++;
                if (sm_valid !== 4'b0001 || softmax_en !== 1'b1 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL first_out: v=%b en=%b busy=%b, want 0001 1 1", sm_valid, softmax_en, busy);
                end
            end
            if (in_valid && in_ready) begin
                acc++;
                if (first < 0) first = cyc;
                last = cyc;
            end
        end
        @(posedge clk); #1 in_valid = 1'b0;
        total++;
        if (acc !== 32 || (last - first + 1) !== 32) begin
            bad++;
            $display("FAIL stream_rate: accepted=%0d span=%0d, want 32 32", acc, last - first + 1);
        end
        for (int i = 0; i < 50 && n_pop < 32; i++) @(negedge clk);
        @(negedge clk);
        total++;
        if (n_pop !== 32 || q.size() !== 0 || busy !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL stream_end: pops=%0d left=%0d busy=%b rdy=%b, want 32 0 1 0",
                     n_pop, q.size(), busy, in_ready);
        end
    endtask

    task automatic test_completion();
        pulse_done(4'b1000);
        pulse_done(4'b0010);
        pulse_done(4'b0001);
        pulse_done(4'b1000);    // already flagged
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b1 || slice_done !== 1'b0 || b2r_rst_n !== 1'b1) begin
            bad++;
            $display("FAIL drain_wait: busy=%b sd=%b b2r=%b, want 1 0 1", busy, slice_done, b2r_rst_n);
        end
        pulse_done(4'b0100);
        check_flush("completion");
    endtask

    task automatic test_backpressure();
        logic [TW-1:0] d0;
        bit found = 0;
        sm_ready = 4'b1011;
        start_slice();
        in_valid = 1'b1;
        pulse_done(4'b0001);    // early done during STREAM
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sm_valid === 4'b0100) begin found = 1; break; end
        end
        d0 = sm_data;
        total++;
        if (!found) begin
            bad++;
            $display("FAIL bp_found: sm_valid=%b, want 0100 within 50 cycles", sm_valid);
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            total++;
            if (sm_valid !== 4'b0100 || sm_data !== d0 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold: cycle %0d v=%b rdy=%b data=%h, want 0100 0 %h",
                         i, sm_valid, in_ready, sm_data, d0);
            end
        end
        @(posedge clk); #1 sm_ready = '1;
        for (int i = 0; i < 200 && n_pop < 32; i++) @(negedge clk);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (n_push !== 32 || n_pop !== 32 || q.size() !== 0) begin
            bad++;
            $display("FAIL bp_count: pushed=%0d popped=%0d left=%0d, want 32 32 0", n_push, n_pop, q.size());
        end
    endtask

    task automatic test_early_done();
        in_valid = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || n_push !== 32 || slice_done !== 1'b0) begin
            bad++;
            $display("FAIL drain_start_ignored: busy=%b rdy=%b pushed=%0d sd=%b, want 1 0 32 0",
                     busy, in_ready, n_push, slice_done);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        pulse_done(4'b0010);
        pulse_done(4'b0100);
        pulse_done(4'b1000);
        check_flush("early_done");
`ifdef STALL_CNT_EN
        total++;
        if (stall_cnt !== 32'(stall_seen)) begin
            bad++;
            $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, stall_seen);
        end
`endif
    endtask

    task automatic test_reset_mid();
        start_slice();
        in_valid = 1'b1;
`ifdef STALL_CNT_EN
        @(negedge clk);
        total++;
        if (stall_cnt !== 32'd0) begin
            bad++;
            $display("FAIL stall_clear: got %0d want 0", stall_cnt);
        end
`endif
        for (int i = 0; i < 100 && n_push < 13; i++) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({in_ready, sm_valid, sm_tile_idx, sm_last, softmax_en, b2r_rst_n, slice_done, busy} !== '0 ||
            sm_data !== '0) begin
            bad++;
            $display("FAIL reset_mid: rdy=%b v=%b idx=%0d last=%b en=%b b2r=%b sd=%b busy=%b, want all 0",
                     in_ready, sm_valid, sm_tile_idx, sm_last, softmax_en, b2r_rst_n, slice_done, busy);
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        bit found = 0;
        start_slice();
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (|sm_valid) begin found = 1; break; end
        end
        total++;
        if (!found || sm_valid !== 4'b0001 || sm_tile_idx !== 3'd0) begin
            bad++;
            $display("FAIL restart_first: v=%b idx=%0d, want 0001 0", sm_valid, sm_tile_idx);
        end
        for (int i = 0; i < 40 && n_pop < 32; i++) @(negedge clk);
        @(posedge clk); #1 in_valid = 1'b0;
        total++;
        if (n_pop !== 32) begin
            bad++;
            $display("FAIL restart_stream: popped=%0d want 32", n_pop);
        end
        pulse_done('1);
        check_flush("restart_done");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        in_data = '0;
        test_reset();
        test_stream();
        test_completion();
        test_backpressure();
        test_early_done();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
